pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock shared with the IF/ID, ID/EX and EX/MEM registers.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
REQ-005 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-006 ex_rt  in  5  rt field held in ID/EX.
REQ-007 ex_mem_read  in  1  ID/EX instruction is a load (MEM control, read bit).
REQ-008 ex_busy_start  in  1  ID/EX instruction needs multi-cycle EX.
REQ-009 ex_busy_len  in  4  stall cycles requested by that instruction.
REQ-010 branch_taken  in  1  bne resolved taken in MEM.
REQ-011 pc_write, ifid_write  out  1 each  write enables for PC and IF/ID.
REQ-012 idex_bubble  out  1  load zeros into WB/MEM/EX control fields of ID/EX.
REQ-013 idex_hold  out  1  ID/EX keeps its current contents.
REQ-014 exmem_bubble  out  1  load zero controls into EX/MEM.
REQ-015 ifid_flush, idex_flush, exmem_flush  out  1 each  squash the corresponding register.
REQ-016 state  out  2  current FSM state.
REQ-017 stall_cycles, flush_events  out  16 each  performance counters.

Function
REQ-018 FSM states SHALL be RUN=2'b00, BUSY=2'b01, FLUSH=2'b10; 2'b11 SHALL go to RUN on the next edge with RUN outputs.
REQ-019 Outputs SHALL be combinational from state and inputs (zero latency); state and counters SHALL be registered.
REQ-020 Default outputs: pc_write=1, ifid_write=1, all bubble/hold/flush=0.
REQ-021 load_use SHALL equal ex_mem_read AND ex_rt!=0 AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)).
REQ-022 Priority in every state SHALL be branch_taken > BUSY/busy_start > load_use.
REQ-023 branch_taken (any state): all three flush outputs=1, pc_write=1, ifid_write=1; next state FLUSH; busy counter cleared to 0.
REQ-024 RUN with ex_busy_start and ex_busy_len=N>0: same cycle pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1; cnt<=N-1; next BUSY if N>1 else RUN.
REQ-025 RUN with ex_busy_start and ex_busy_len=0: request ignored.
REQ-026 BUSY: same stall outputs as REQ-024; cnt==1 -> cnt<=0, next RUN; otherwise cnt<=cnt-1. Total stall SHALL be exactly N cycles.
REQ-027 ex_busy_start while in BUSY SHALL be ignored; load_use SHALL NOT be evaluated in BUSY.
REQ-028 RUN with load_use only: pc_write=0, ifid_write=0, idex_bubble=1 for that cycle; state stays RUN.
REQ-029 FLUSH: default outputs, load_use and ex_busy_start ignored; next RUN.

Reset
REQ-030 rst_n low SHALL immediately force state=RUN, cnt=0 and counters=0, independent of clk.
REQ-031 Reset asserted in BUSY SHALL abandon the stall; the first cycle after release SHALL be RUN.

Configuration
REQ-032 Macro HAZARD_CTRL_STATS_EN defined: stall_cycles SHALL increment each cycle pc_write=0; flush_events SHALL increment each cycle branch_taken=1; both SHALL saturate at 16'hFFFF.
REQ-033 HAZARD_CTRL_STATS_EN undefined: ports present, tied to 0, no counter flops.

Verification
REQ-034 ex_mem_read=1, ex_rt=5, id_rs=5 in RUN -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; state stays 00.
REQ-035 Same as REQ-034 with ex_rt=0, or id_rt=5 with id_uses_rt=0 and id_rs!=5 -> no stall.
REQ-036 ex_busy_start=1, ex_busy_len=4 -> exactly 4 consecutive cycles of idex_hold=1; state 00,01,01,01 then 00.
REQ-037 branch_taken=1 on 2nd BUSY cycle of len=4 -> flush outputs=1 that cycle, state 10 next, then 00; no further hold.
REQ-038 Simultaneous branch_taken, ex_busy_start and load_use in RUN -> flush only; next state FLUSH.
REQ-039 With HAZARD_CTRL_STATS_EN, REQ-036 then REQ-034 -> stall_cycles=5; rst_n pulse mid-BUSY -> counters=0, state=00 asynchronously.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use, multi-cycle EX and taken-branch hazards.
// Outputs are combinational from state and inputs; HAZARD_CTRL_STATS_EN adds saturating perf counters.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        ex_busy_start,
  input  logic [3:0]  ex_busy_len,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        idex_hold,
  output logic        exmem_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;

  assign state = state_q;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    state_d      = ST_RUN;
    cnt_d        = cnt_q;

    if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = ST_FLUSH;
      cnt_d       = 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_busy_start && (ex_busy_len != 4'd0)) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            cnt_d        = ex_busy_len - 4'd1;
            state_d      = (ex_busy_len > 4'd1) ? ST_BUSY : ST_RUN;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        ST_BUSY: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
          // cnt==0 cannot occur here normally; treat it like the last cycle
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = ST_RUN;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            state_d = ST_BUSY;
          end
        end
        default: begin
          cnt_d   = 4'd0;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_write && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
    if (branch_taken && (flush_events_q != 16'hFFFF)) flush_events_d = flush_events_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 16'd0;
      flush_events_q <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = 16'd0;
  assign flush_events = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; counter expectations follow HAZARD_CTRL_STATS_EN.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, ex_busy_start, branch_taken;
  logic [3:0]  ex_busy_len;
  logic        pc_write, ifid_write, idex_bubble, idex_hold, exmem_bubble;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  // {pc_write, ifid_write, idex_bubble, idex_hold, exmem_bubble, ifid_flush, idex_flush, exmem_flush}
  logic [7:0] outs;
  localparam logic [7:0] O_DEF   = 8'b1100_0000;
  localparam logic [7:0] O_LU    = 8'b0010_0000;
  localparam logic [7:0] O_STALL = 8'b0001_1000;
  localparam logic [7:0] O_FLUSH = 8'b1100_0111;

`ifdef HAZARD_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  assign outs = {pc_write, ifid_write, idex_bubble, idex_hold, exmem_bubble,
                 ifid_flush, idex_flush, exmem_flush};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_busy_start(ex_busy_start), .ex_busy_len(ex_busy_len),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_bubble(exmem_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .state(state), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; ex_busy_start = 1'b0; ex_busy_len = 4'd0; branch_taken = 1'b0;
  endtask

  // advance one edge, then let inputs change away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #2;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", state); end
    total++; if (outs !== O_DEF) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, O_DEF); end
    total++; if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL post_reset_state got=%b exp=00", state); end
  endtask

  task automatic test_busy();
    logic [1:0] exp_st [4] = '{2'b00, 2'b01, 2'b01, 2'b01};
    ex_busy_start = 1'b1; ex_busy_len = 4'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (state !== exp_st[i] || outs !== O_STALL) begin
        bad++; $display("FAIL busy_cycle%0d got st=%b outs=%b exp st=%b outs=%b", i, state, outs, exp_st[i], O_STALL);
      end
      tick();
    end
    clear_inputs();
    #1;
    total++; if (state !== 2'b00 || outs !== O_DEF) begin
      bad++; $display("FAIL busy_end got st=%b outs=%b exp st=00 outs=%b", state, outs, O_DEF);
    end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    total++; if (outs !== O_LU || state !== 2'b00) begin
      bad++; $display("FAIL load_use got st=%b outs=%b exp st=00 outs=%b", state, outs, O_LU);
    end
    tick();
    clear_inputs();
    #1;
    total++; if (state !== 2'b00 || outs !== O_DEF) begin
      bad++; $display("FAIL load_use_after got st=%b outs=%b exp st=00 outs=%b", state, outs, O_DEF);
    end
    total++; if (stall_cycles !== (STATS ? 16'd5 : 16'd0)) begin
      bad++; $display("FAIL stall_count got=%0d exp=%0d", stall_cycles, STATS ? 5 : 0);
    end
  endtask

  task automatic test_no_stall();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    total++; if (outs !== O_DEF) begin bad++; $display("FAIL lu_rt0 got=%b exp=%b", outs, O_DEF); end
    ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1;
    total++; if (outs !== O_DEF) begin bad++; $display("FAIL lu_rt_unused got=%b exp=%b", outs, O_DEF); end
    id_uses_rt = 1'b1;
    #1;
    total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rt_used got=%b exp=%b", outs, O_LU); end
    ex_mem_read = 1'b0;
    #1;
    total++; if (outs !== O_DEF) begin bad++; $display("FAIL lu_no_load got=%b exp=%b", outs, O_DEF); end
    clear_inputs();
  endtask

  task automatic test_busy_len_edges();
    ex_busy_start = 1'b1; ex_busy_len = 4'd0;
    #1;
    total++; if (outs !== O_DEF) begin bad++; $display("FAIL busy_len0 got=%b exp=%b", outs, O_DEF); end
    ex_busy_len = 4'd1;
    #1;
    total++; if (outs !== O_STALL) begin bad++; $display("FAIL busy_len1 got=%b exp=%b", outs, O_STALL); end
    tick();
    clear_inputs();
    #1;
    total++; if (state !== 2'b00 || outs !== O_DEF) begin
      bad++; $display("FAIL busy_len1_after got st=%b outs=%b exp st=00 outs=%b", state, outs, O_DEF);
    end
  endtask

  task automatic test_branch_in_busy();
    ex_busy_start = 1'b1; ex_busy_len = 4'd4;
    tick();
    tick();
    branch_taken = 1'b1;
    #1;
    total++; if (state !== 2'b01 || outs !== O_FLUSH) begin
      bad++; $display("FAIL branch_busy got st=%b outs=%b exp st=01 outs=%b", state, outs, O_FLUSH);
    end
    tick();
    clear_inputs();
    #1;
    total++; if (state !== 2'b10 || outs !== O_DEF) begin
      bad++; $display("FAIL branch_busy_flush got st=%b outs=%b exp st=10 outs=%b", state, outs, O_DEF);
    end
    tick();
    total++; if (state !== 2'b00 || outs !== O_DEF) begin
      bad++; $display("FAIL branch_busy_run got st=%b outs=%b exp st=00 outs=%b", state, outs, O_DEF);
    end
    tick();
    total++; if (state !== 2'b00 || idex_hold !== 1'b0) begin
      bad++; $display("FAIL branch_busy_nohold got st=%b hold=%b exp st=00 hold=0", state, idex_hold);
    end
  endtask

  task automatic test_simultaneous();
    branch_taken = 1'b1; ex_busy_start = 1'b1; ex_busy_len = 4'd3;
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    #1;
    total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL simul_outs got=%b exp=%b", outs, O_FLUSH); end
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if (state !== 2'b10 || outs !== O_DEF) begin
      bad++; $display("FAIL simul_flush_state got st=%b outs=%b exp st=10 outs=%b", state, outs, O_DEF);
    end
    clear_inputs();
    tick();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL simul_run got=%b exp=00", state); end
    total++; if (flush_events !== (STATS ? 16'd2 : 16'd0)) begin
      bad++; $display("FAIL flush_count got=%0d exp=%0d", flush_events, STATS ? 2 : 0);
    end
  endtask

  task automatic test_reset_mid_busy();
    ex_busy_start = 1'b1; ex_busy_len = 4'd4;
    tick();
    clear_inputs();
    #1;
    total++; if (state !== 2'b01) begin bad++; $display("FAIL rmb_in_busy got=%b exp=01", state); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (state !== 2'b00 || outs !== O_DEF) begin
      bad++; $display("FAIL rmb_async got st=%b outs=%b exp st=00 outs=%b", state, outs, O_DEF);
    end
    total++; if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      bad++; $display("FAIL rmb_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (state !== 2'b00 || idex_hold !== 1'b0) begin
      bad++; $display("FAIL rmb_release got st=%b hold=%b exp st=00 hold=0", state, idex_hold);
    end
  endtask

  initial begin
    test_reset();
    test_busy();
    test_load_use();
    test_no_stall();
    test_busy_len_edges();
    test_branch_in_busy();
    test_simultaneous();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
